// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and constants for the pipeline sequencer.
// Optional feature macro used by the block: PIPELINE_CTRL_PERF_EN.
package pipeline_ctrl_pkg;

    // Top-level sequencer states.
    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        VECTOR
    } pipe_state_t;

    // Default exception handler address.
    localparam logic [31:0] ExcVectorDefault = 32'h8000_0080;

    // Winning request in RUN after priority resolution.
    typedef enum logic [2:0] {
        PrioNone,
        PrioWait,
        PrioExc,
        PrioLoad,
        PrioBranch
    } run_prio_t;

    // Priority: mem_wait > exception > load_hazard > br_taken.
    function automatic run_prio_t run_decide(
        input logic mem_wait,
        input logic exception,
        input logic load_hazard,
        input logic br_taken
    );
        run_prio_t prio;
        if (mem_wait) begin
            prio = PrioWait;
        end else if (exception) begin
            prio = PrioExc;
        end else if (load_hazard) begin
            prio = PrioLoad;
        end else if (br_taken) begin
            prio = PrioBranch;
        end else begin
            prio = PrioNone;
        end
        return prio;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/exception requests into the sequencer and the
// stall, flush and PC-redirect controls it drives back into the pipeline.
// Optional feature macro used by the block: PIPELINE_CTRL_PERF_EN (no effect here).
interface pipeline_ctrl_if;

    // Requests from decode / memory.
    logic        load_hazard;
    logic        br_taken;
    logic        exception;
    logic [31:0] exc_pc;
    logic        mem_wait;

    // Controls back to the pipeline.
    logic        hold_pc;
    logic        hold_if;
    logic        hold_id;
    logic        flush_if;
    logic        flush_id;
    logic        pc_override;
    logic [31:0] pc_target;
    logic [31:0] epc;
    logic        exc_active;

    // Pipeline side: raises requests, consumes controls.
    modport master (
        output load_hazard, br_taken, exception, exc_pc, mem_wait,
        input  hold_pc, hold_if, hold_id, flush_if, flush_id,
        input  pc_override, pc_target, epc, exc_active
    );

    // Sequencer side.
    modport slave (
        input  load_hazard, br_taken, exception, exc_pc, mem_wait,
        output hold_pc, hold_if, hold_id, flush_if, flush_id,
        output pc_override, pc_target, epc, exc_active
    );

endinterface

// File: rtl/pipeline_ctrl_perf.sv
// pipeline_ctrl_perf: saturating stall and flush event counters.
// Instantiated by pipeline_ctrl only when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_ctrl_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_inc,
    input  logic        flush_inc,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [31:0] CntMax = 32'hFFFF_FFFF;

    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Count events, sticking at all-ones; cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc && (stall_cnt_q != CntMax)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_inc && (flush_cnt_q != CntMax)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Handles load-use stalls, taken branches, memory waits and the exception
// drain/vector sequence. Define PIPELINE_CTRL_PERF_EN to add the
// stall_cnt/flush_cnt performance counter outputs.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = ExcVectorDefault,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_ctrl_if.slave        ctl
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    // Counter reload so that exactly DRAIN_CYCLES cycles are spent in DRAIN.
    localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES - 1);

    pipe_state_t state_q;
    logic [3:0]  cnt_q;
    logic [31:0] epc_q;
    run_prio_t   prio;

    logic hold_pc;
    logic hold_if;
    logic hold_id;
    logic flush_if;
    logic flush_id;
    logic pc_override;
    logic exc_active;

    assign prio = run_decide(ctl.mem_wait, ctl.exception, ctl.load_hazard, ctl.br_taken);

    // Sequencer state, drain counter and EPC capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            epc_q   <= 32'd0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (prio == PrioExc) begin
                        epc_q   <= ctl.exc_pc;
                        cnt_q   <= DrainLoad;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A memory wait freezes the drain so older instructions still retire.
                    if (!ctl.mem_wait) begin
                        if (cnt_q == 4'd0) begin
                            state_q <= VECTOR;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                VECTOR: begin
                    if (!ctl.mem_wait) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    // Same-cycle control decode from state and requests; silenced during reset.
    always_comb begin
        hold_pc     = 1'b0;
        hold_if     = 1'b0;
        hold_id     = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        pc_override = 1'b0;
        exc_active  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    unique case (prio)
                        PrioWait: begin
                            hold_pc = 1'b1;
                            hold_if = 1'b1;
                            hold_id = 1'b1;
                        end
                        PrioExc: begin
                            flush_if = 1'b1;
                            flush_id = 1'b1;
                        end
                        PrioLoad: begin
                            // Branch in ID saw stale operands; it re-resolves next cycle.
                            hold_pc  = 1'b1;
                            hold_if  = 1'b1;
                            flush_id = 1'b1;
                        end
                        PrioBranch: begin
                            flush_if = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                DRAIN: begin
                    hold_pc    = 1'b1;
                    flush_if   = 1'b1;
                    flush_id   = 1'b1;
                    exc_active = 1'b1;
                    hold_id    = ctl.mem_wait;
                end
                VECTOR: begin
                    pc_override = 1'b1;
                    flush_if    = 1'b1;
                    exc_active  = 1'b1;
                    hold_if     = ctl.mem_wait;
                    hold_id     = ctl.mem_wait;
                end
                default: begin
                end
            endcase
        end
    end

    assign ctl.hold_pc     = hold_pc;
    assign ctl.hold_if     = hold_if;
    assign ctl.hold_id     = hold_id;
    assign ctl.flush_if    = flush_if;
    assign ctl.flush_id    = flush_id;
    assign ctl.pc_override = pc_override;
    assign ctl.pc_target   = EXC_VECTOR;
    assign ctl.epc         = epc_q;
    assign ctl.exc_active  = exc_active;

`ifdef PIPELINE_CTRL_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = (state_q == RUN) && (ctl.load_hazard || ctl.mem_wait);
    assign flush_inc = (state_q == RUN) && ((prio == PrioExc) || (prio == PrioBranch));

    pipeline_ctrl_perf u_perf (
        .clk       (clk),
        .rst       (rst),
        .stall_inc (stall_inc),
        .flush_inc (flush_inc),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks of pipeline_ctrl against a
// behavioural model of the sequencer rules. Honours PIPELINE_CTRL_PERF_EN.
module tb_pipeline_ctrl;

    localparam int unsigned Drain = 3;
    localparam logic [31:0] Vec   = 32'h8000_0080;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lh  = 1'b0;
    logic        br  = 1'b0;
    logic        ex  = 1'b0;
    logic [31:0] xpc = 32'd0;
    logic        mw  = 1'b0;

    int checks   = 0;
    int failures = 0;

    pipeline_ctrl_if bus ();

    assign bus.load_hazard = lh;
    assign bus.br_taken    = br;
    assign bus.exception   = ex;
    assign bus.exc_pc      = xpc;
    assign bus.mem_wait    = mw;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipeline_ctrl #(
        .EXC_VECTOR   (Vec),
        .DRAIN_CYCLES (Drain)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ctl       (bus.slave)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // {hold_pc, hold_if, hold_id, flush_if, flush_id, pc_override, exc_active}
    logic [6:0] act_ctrl;
    assign act_ctrl = {bus.hold_pc, bus.hold_if, bus.hold_id, bus.flush_if,
                       bus.flush_id, bus.pc_override, bus.exc_active};

    // Model: an exception is pending while drain_left > 0, then one vector phase.
    bit          m_valid = 1'b0;
    int          m_drain_left = 0;
    bit          m_vec = 1'b0;
    logic [31:0] m_epc = 32'd0;
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_flush = 32'd0;

    function automatic logic [6:0] model_ctrl();
        logic [6:0] e;
        e = 7'b0;
        if (rst) begin
            e = 7'b0;
        end else if (m_vec) begin
            e = {1'b0, mw, mw, 1'b1, 1'b0, 1'b1, 1'b1};
        end else if (m_drain_left > 0) begin
            e = {1'b1, 1'b0, mw, 1'b1, 1'b1, 1'b0, 1'b1};
        end else if (mw) begin
            e = 7'b1110000;
        end else if (ex) begin
            e = 7'b0001100;
        end else if (lh) begin
            e = 7'b1100100;
        end else if (br) begin
            e = 7'b0001000;
        end
        return e;
    endfunction

    // Advance the model on each clock edge.
    always @(posedge clk) begin
        if (rst) begin
            m_valid      <= 1'b1;
            m_drain_left <= 0;
            m_vec        <= 1'b0;
            m_epc        <= 32'd0;
            m_stall      <= 32'd0;
            m_flush      <= 32'd0;
        end else if (m_vec) begin
            if (!mw) m_vec <= 1'b0;
        end else if (m_drain_left > 0) begin
            if (!mw) begin
                m_drain_left <= m_drain_left - 1;
                if (m_drain_left == 1) m_vec <= 1'b1;
            end
        end else begin
            if ((lh || mw) && m_stall != 32'hFFFF_FFFF) m_stall <= m_stall + 32'd1;
            if (!mw && (ex || (br && !lh)) && m_flush != 32'hFFFF_FFFF)
                m_flush <= m_flush + 32'd1;
            if (!mw && ex) begin
                m_epc        <= xpc;
                m_drain_left <= Drain;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (act_ctrl !== model_ctrl()) begin
                failures++;
                $display("FAIL ctrl t=%0t got=%b expected=%b", $time, act_ctrl, model_ctrl());
            end
            checks++;
            if (bus.epc !== m_epc) begin
                failures++;
                $display("FAIL epc t=%0t got=%h expected=%h", $time, bus.epc, m_epc);
            end
            checks++;
            if (bus.pc_target !== Vec) begin
                failures++;
                $display("FAIL pc_target t=%0t got=%h expected=%h", $time, bus.pc_target, Vec);
            end
`ifdef PIPELINE_CTRL_PERF_EN
            checks++;
            if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
                failures++;
                $display("FAIL perf t=%0t got=%0d/%0d expected=%0d/%0d", $time,
                         stall_cnt, flush_cnt, m_stall, m_flush);
            end
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, then wait for the sample point.
    task automatic cyc(input logic r, input logic l, input logic b, input logic e,
                       input logic [31:0] p, input logic m);
        @(posedge clk);
        #1;
        rst = r;
        lh  = l;
        br  = b;
        ex  = e;
        xpc = p;
        mw  = m;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_ovr;
        // Reset
        cyc(1, 0, 0, 0, 0, 0);  chk("rst_ctrl0", 32'(act_ctrl), 32'h0);
        cyc(1, 0, 0, 0, 0, 0);  chk("rst_ctrl1", 32'(act_ctrl), 32'h0);
        cyc(0, 0, 0, 0, 0, 0);  chk("idle_ctrl", 32'(act_ctrl), 32'h0);
        chk("rst_epc", bus.epc, 32'h0);

        // Load-use, branch, branch under load hazard, wait over everything
        cyc(0, 1, 0, 0, 0, 0);  chk("load_use", 32'(act_ctrl), 32'h64);
        cyc(0, 0, 0, 0, 0, 0);  chk("load_release", 32'(act_ctrl), 32'h0);
        cyc(0, 0, 1, 0, 0, 0);  chk("branch", 32'(act_ctrl), 32'h08);
        cyc(0, 1, 1, 0, 0, 0);  chk("branch_load", 32'(act_ctrl), 32'h64);
        cyc(0, 1, 1, 1, 32'h0040_0000, 1);  chk("wait_exc", 32'(act_ctrl), 32'h70);

        // Exception: 3 drain cycles then one vector cycle
        cyc(0, 0, 0, 1, 32'h0040_0010, 0);  chk("exc_run", 32'(act_ctrl), 32'h0C);
        cyc(0, 0, 0, 0, 0, 0);  chk("drain1", 32'(act_ctrl), 32'h4D);
        chk("epc_cap", bus.epc, 32'h0040_0010);
        cyc(0, 0, 0, 0, 0, 0);  chk("drain2", 32'(act_ctrl), 32'h4D);
        cyc(0, 0, 0, 0, 0, 0);  chk("drain3", 32'(act_ctrl), 32'h4D);
        cyc(0, 0, 0, 0, 0, 0);  chk("vector", 32'(act_ctrl), 32'h0B);
        chk("vec_target", bus.pc_target, 32'h8000_0080);
        cyc(0, 0, 0, 0, 0, 0);  chk("back_run", 32'(act_ctrl), 32'h0);

        // Wait inside drain and vector stretches the sequence
        cyc(0, 0, 0, 1, 32'h0040_0020, 0);  chk("exc2_run", 32'(act_ctrl), 32'h0C);
        cyc(0, 0, 0, 0, 0, 0);  chk("d_a", 32'(act_ctrl), 32'h4D);
        cyc(0, 0, 0, 0, 0, 1);  chk("d_wait1", 32'(act_ctrl), 32'h5D);
        cyc(0, 1, 1, 1, 32'h1, 1);  chk("d_wait2", 32'(act_ctrl), 32'h5D);
        cyc(0, 0, 0, 0, 0, 0);  chk("d_b", 32'(act_ctrl), 32'h4D);
        cyc(0, 0, 0, 0, 0, 0);  chk("d_c", 32'(act_ctrl), 32'h4D);
        cyc(0, 0, 0, 0, 0, 1);  chk("vec_wait", 32'(act_ctrl), 32'h3B);
        cyc(0, 0, 0, 0, 0, 0);  chk("vec_go", 32'(act_ctrl), 32'h0B);
        cyc(0, 0, 0, 0, 0, 0);  chk("run2", 32'(act_ctrl), 32'h0);
        chk("epc2", bus.epc, 32'h0040_0020);

        // Reset mid-drain aborts the vector
        cyc(0, 0, 0, 1, 32'h0040_0030, 0);  chk("exc3_run", 32'(act_ctrl), 32'h0C);
        cyc(0, 0, 0, 0, 0, 0);  chk("d3_1", 32'(act_ctrl), 32'h4D);
        cyc(1, 0, 0, 0, 0, 0);  chk("d3_rst", 32'(act_ctrl), 32'h0);
        cyc(0, 0, 0, 0, 0, 0);  chk("post_rst", 32'(act_ctrl), 32'h0);
        chk("post_rst_epc", bus.epc, 32'h0);
`ifdef PIPELINE_CTRL_PERF_EN
        chk("post_rst_stall", stall_cnt, 32'h0);
        chk("post_rst_flush", flush_cnt, 32'h0);
`endif
        saw_ovr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            if (bus.pc_override) saw_ovr = 1'b1;
        end
        chk("no_vector", 32'(saw_ovr), 32'h0);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 19) == 0),
                $urandom,
                ($urandom_range(0, 4) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencer for the 5-stage MIPS R2000 pipeline. It takes the decode-stage hazard request, the branch decision, the illegal-opcode exception and the data-memory wait. From these it drives the stall and flush controls for the IF/ID and ID/EX registers. It also owns PC redirection for exceptions: it drains in-flight instructions, captures the EPC, then forces the fetch PC to the exception vector.

## Interface
Parameters:
- EXC_VECTOR, 32'h8000_0080, exception handler address driven on pc_target in VECTOR.
- DRAIN_CYCLES, 3, cycles spent in DRAIN so EX/MEM/WB retire; legal range 1..15.

Ports:
- clk  in  1  single pipeline clock, posedge.
- rst  in  1  synchronous, active-high reset, sampled on posedge clk.
- load_hazard  in  1  load-use request from the decode hazard unit.
- br_taken  in  1  branch/jump resolved taken in ID this cycle.
- exception  in  1  illegal opcode decoded in ID this cycle.
- exc_pc  in  32  PC of the instruction in ID.
- mem_wait  in  1  data memory not ready; the whole pipe must freeze.
- hold_pc  out  1  PC register keeps its value.
- hold_if  out  1  IF/ID register keeps its value.
- hold_id  out  1  ID/EX register keeps its value.
- flush_if  out  1  IF/ID loads a NOP.
- flush_id  out  1  control unit outputs zero controls (bubble into ID/EX).
- pc_override  out  1  PC mux selects pc_target.
- pc_target  out  32  redirect address.
- epc  out  32  captured exception PC.
- exc_active  out  1  high in DRAIN and VECTOR.

## Operation
- States: RUN, DRAIN, VECTOR. A 4-bit down-counter cnt is used in DRAIN.
- Control outputs are combinational from state and inputs, so decode sees them in the same cycle. All are 0 unless listed below.
- RUN priority is mem_wait > exception > load_hazard > br_taken:
  - mem_wait: hold_pc=hold_if=hold_id=1. No flush and no state change. Every lower-priority input is ignored this cycle.
  - exception: flush_if=flush_id=1. On the clock edge, epc<=exc_pc, cnt<=DRAIN_CYCLES-1, state->DRAIN.
  - load_hazard: hold_pc=hold_if=flush_id=1. br_taken is suppressed, because the branch compared stale operands and re-resolves next cycle.
  - br_taken: flush_if=1. The PC mux uses pc_branch outside this block.
- DRAIN:
  - Outputs: hold_pc=flush_if=flush_id=1, exc_active=1.
  - mem_wait additionally asserts hold_id and freezes cnt.
  - exception, load_hazard and br_taken are ignored.
  - When cnt==0 and mem_wait is low, state->VECTOR. Otherwise cnt decrements.
- VECTOR:
  - Outputs: pc_override=1, pc_target=EXC_VECTOR, flush_if=1, exc_active=1.
  - If mem_wait is low, state->RUN on the next edge.
  - If mem_wait is high: stay in VECTOR, keep pc_override asserted, and assert hold_if and hold_id.
- pc_target equals EXC_VECTOR at all times. It is only meaningful when pc_override=1.
- epc is written only on RUN->DRAIN and holds its value otherwise.

## Timing
- Reset: on a posedge with rst=1, state<=RUN, cnt<=0, epc<=0, and the performance counters are cleared. While rst=1, every combinational control output is forced to 0.
- Reset mid-DRAIN or mid-VECTOR aborts the sequence. epc returns to 0 and no vector is taken.
- Stall and flush controls have 0-cycle latency (combinational).
- Exception to pc_override: DRAIN_CYCLES+1 edges when mem_wait stays low. Each mem_wait cycle adds one edge.
- A load-use stall lasts exactly one cycle per load_hazard assertion. The block never holds a stall beyond its input.
- Simultaneous exception and mem_wait in RUN: the exception is not taken that cycle. It is taken once mem_wait drops, provided exception is still asserted (it is, because ID is held).

## Configuration
- PIPELINE_CTRL_PERF_EN defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on every RUN cycle with load_hazard=1 or mem_wait=1.
  - flush_cnt increments on every RUN cycle in which br_taken or exception is accepted.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- PIPELINE_CTRL_PERF_EN undefined: these ports and the counter logic are absent. Behaviour is otherwise identical.

## Structure
- Package pipeline_ctrl_pkg holds:
  - typedef enum logic [1:0] pipe_state_t {RUN, DRAIN, VECTOR};
  - the default EXC_VECTOR constant;
  - a priority-code typedef for RUN decisions.
- Sub-module pipeline_ctrl_perf holds the two saturating counters. It is instantiated only under PIPELINE_CTRL_PERF_EN.
- The FSM and the combinational output decode stay in pipeline_ctrl.

## Test plan
- Load-use: load_hazard=1 for one cycle in RUN -> hold_pc=hold_if=flush_id=1 that cycle and all outputs 0 the next.
- Branch: br_taken=1 -> flush_if=1 for one cycle. br_taken=1 together with load_hazard=1 -> flush_if=0, flush_id=1.
- Exception: exception=1, exc_pc=32'h0040_0010, DRAIN_CYCLES=3 ->
  - epc=32'h0040_0010 on the next edge;
  - 3 DRAIN cycles, then 1 VECTOR cycle with pc_override=1 and pc_target=32'h8000_0080;
  - then RUN.
- Wait during DRAIN: mem_wait=1 for 2 cycles inside DRAIN -> cnt frozen, hold_id=1, VECTOR reached 2 cycles later than without the wait.
- Reset mid-sequence: rst=1 in the second DRAIN cycle -> next edge state=RUN and epc=0, pc_override never asserts. With PIPELINE_CTRL_PERF_EN, the counters read 0.
